// File: rtl/imm_gen_if.sv
// Handshake bundle carrying instruction words into the immediate generator
// and extended immediates out towards the ID/EX register.
interface imm_gen_if #(
   parameter int XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     instr;
   logic [2:0]      imm_src;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] imm_ext;
   logic            imm_err;

   // Surrounding pipeline: offers instructions, consumes immediates.
   modport master (
      output in_valid, instr, imm_src, out_ready,
      input  in_ready, out_valid, imm_ext, imm_err
   );

   // Immediate generator.
   modport slave (
      input  in_valid, instr, imm_src, out_ready,
      output in_ready, out_valid, imm_ext, imm_err
   );
endinterface

// File: rtl/imm_gen_stage.sv
// Decode-stage immediate generator. Extends the immediate of each accepted
// instruction combinationally, stores it already extended in an output
// register, and absorbs one extra entry in a skid register so that in_ready
// can be driven purely from state.
module imm_gen_stage #(
   parameter int XLEN = 32
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     flush,
   imm_gen_if.slave bus
);

   localparam logic [2:0] SRC_I   = 3'b000;
   localparam logic [2:0] SRC_S   = 3'b001;
   localparam logic [2:0] SRC_B   = 3'b010;
   localparam logic [2:0] SRC_J   = 3'b011;
   localparam logic [2:0] SRC_U   = 3'b100;
   localparam logic [2:0] SRC_Z   = 3'b101;
   localparam logic [2:0] SRC_SH  = 3'b110;
   localparam logic [2:0] SRC_RSV = 3'b111;

   if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("imm_gen_stage: XLEN must be 32 or 64");
   end

   // Widen a 32-bit signed value to the datapath width.
   function automatic logic signed [XLEN-1:0] sext32(input logic signed [31:0] v);
      return XLEN'(v);
   endfunction

   function automatic logic signed [XLEN-1:0] imm_i(input logic [31:7] f);
      logic signed [11:0] raw;
      raw = f[31:20];
      return sext32(32'(raw));
   endfunction

   function automatic logic signed [XLEN-1:0] imm_s(input logic [31:7] f);
      logic signed [11:0] raw;
      raw = {f[31:25], f[11:7]};
      return sext32(32'(raw));
   endfunction

   function automatic logic signed [XLEN-1:0] imm_b(input logic [31:7] f);
      logic signed [12:0] raw;
      raw = {f[31], f[7], f[30:25], f[11:8], 1'b0};
      return sext32(32'(raw));
   endfunction

   function automatic logic signed [XLEN-1:0] imm_j(input logic [31:7] f);
      logic signed [20:0] raw;
      raw = {f[31], f[19:12], f[20], f[30:21], 1'b0};
      return sext32(32'(raw));
   endfunction

   function automatic logic signed [XLEN-1:0] imm_u(input logic [31:7] f);
      logic signed [31:0] raw;
      raw = {f[31:12], 12'b0};
      return sext32(raw);
   endfunction

   // Shift amount is 5 bits wide on RV32 and 6 bits wide on RV64.
   function automatic logic signed [XLEN-1:0] imm_sh(input logic [31:7] f);
      logic signed [XLEN-1:0] r;
      if (XLEN == 64) r = XLEN'(f[25:20]);
      else            r = XLEN'(f[24:20]);
      return r;
   endfunction

   // Select and extend the immediate; the reserved code yields zero.
   function automatic logic signed [XLEN-1:0] extend(input logic [31:7] f,
                                                     input logic [2:0]  src);
      logic signed [XLEN-1:0] r;
      case (src)
         SRC_I:   r = imm_i(f);
         SRC_S:   r = imm_s(f);
         SRC_B:   r = imm_b(f);
         SRC_J:   r = imm_j(f);
         SRC_U:   r = imm_u(f);
         SRC_Z:   r = XLEN'(f[19:15]);
         SRC_SH:  r = imm_sh(f);
         default: r = '0;
      endcase
      return r;
   endfunction

   // Opcode bits play no part in immediate extraction.
   logic unused_opcode;
   assign unused_opcode = ^bus.instr[6:0];

   // ---- stage p0: combinational extension of the incoming word ----
   logic [XLEN-1:0] ext_p0;
   logic            err_p0;

   // Extend on the way in so the output side only ever moves finished values.
   always_comb begin
      ext_p0 = extend(bus.instr[31:7], bus.imm_src);
      err_p0 = (bus.imm_src == SRC_RSV);
   end

   // ---- stage p1: output register plus skid register ----
   logic            vld_p1;
   logic            rdy_p1;
   logic            sk_vld_p1;
   logic [XLEN-1:0] imm_p1;
   logic            err_p1;
   logic [XLEN-1:0] sk_imm_p1;
   logic            sk_err_p1;

   logic accept;
   logic drain;
   logic or_load;
   logic vld_nxt;
   logic sk_vld_nxt;

   assign accept  = bus.in_valid & rdy_p1;
   assign drain   = vld_p1 & bus.out_ready;
   assign or_load = ~vld_p1 | drain;

   // Occupancy update: flush empties both entries; a free output register is
   // refilled from the skid entry first, otherwise from the incoming word.
   always_comb begin
      vld_nxt    = vld_p1;
      sk_vld_nxt = sk_vld_p1;
      if (flush) begin
         vld_nxt    = 1'b0;
         sk_vld_nxt = 1'b0;
      end else if (or_load) begin
         vld_nxt    = sk_vld_p1 | accept;
         sk_vld_nxt = sk_vld_p1 & accept;
      end else if (accept) begin
         sk_vld_nxt = 1'b1;
      end
   end

   // Control state; in_ready is registered so it never depends on out_ready.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p1    <= 1'b0;
         sk_vld_p1 <= 1'b0;
         rdy_p1    <= 1'b1;
      end else begin
         vld_p1    <= vld_nxt;
         sk_vld_p1 <= sk_vld_nxt;
         rdy_p1    <= ~sk_vld_nxt;
      end
   end

   // Output register: holds while stalled, takes the older skid entry first.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         imm_p1 <= '0;
         err_p1 <= 1'b0;
      end else if (!flush && or_load) begin
         if (sk_vld_p1) begin
            imm_p1 <= sk_imm_p1;
            err_p1 <= sk_err_p1;
         end else if (accept) begin
            imm_p1 <= ext_p0;
            err_p1 <= err_p0;
         end
      end
   end

   // Skid register: captures an accept that cannot go straight to the output.
   always_ff @(posedge clk) begin
      if (!flush && accept && (sk_vld_p1 || !or_load)) begin
         sk_imm_p1 <= ext_p0;
         sk_err_p1 <= err_p0;
      end
   end

   assign bus.in_ready  = rdy_p1;
   assign bus.out_valid = vld_p1;
   assign bus.imm_ext   = imm_p1;
   assign bus.imm_err   = err_p1;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: an RV32 and an RV64 instance receive identical
// stimulus; directed scenarios plus a randomized soak against a queue model.
module tb_imm_gen_stage;

   logic clk;
   logic rst;
   logic flush;
   int   checks;
   int   failures;

   imm_gen_if #(.XLEN(32)) b32 ();
   imm_gen_if #(.XLEN(64)) b64 ();

   imm_gen_stage #(.XLEN(32)) u_dut32 (.clk(clk), .rst(rst), .flush(flush), .bus(b32));
   imm_gen_stage #(.XLEN(64)) u_dut64 (.clk(clk), .rst(rst), .flush(flush), .bus(b64));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] w;
      logic [2:0]  s;
   } ent_t;

   typedef struct {
      logic [31:0] w;
      logic [2:0]  s;
      logic [31:0] e32;
      logic [63:0] e64;
      logic        err;
   } vec_t;

   // Two's-complement interpretation of a 'bits'-wide field value.
   function automatic longint fold(input longint v, input int bits);
      if (v >= (longint'(1) << (bits - 1))) return v - (longint'(1) << bits);
      return v;
   endfunction

   // Reference immediate, built arithmetically from the field definitions.
   function automatic logic [63:0] ref_imm(input logic [31:0] w, input logic [2:0] s,
                                           input int xlen);
      longint v;
      case (s)
         3'd0: v = fold(longint'(w[31:20]), 12);
         3'd1: v = fold(longint'(w[31:25]) * 32 + longint'(w[11:7]), 12);
         3'd2: v = fold(longint'(w[31]) * 4096 + longint'(w[7]) * 2048 +
                        longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2, 13);
         3'd3: v = fold(longint'(w[31]) * 1048576 + longint'(w[19:12]) * 4096 +
                        longint'(w[20]) * 2048 + longint'(w[30:21]) * 2, 21);
         3'd4: v = fold(longint'(w[31:12]) * 4096, 32);
         3'd5: v = longint'(w[19:15]);
         3'd6: v = (xlen == 64) ? longint'(w[25:20]) : longint'(w[24:20]);
         default: v = 0;
      endcase
      if (xlen == 32) return {32'h0, v[31:0]};
      return v;
   endfunction

   task automatic drive(input logic v, input logic [31:0] w, input logic [2:0] s,
                        input logic ordy, input logic fl);
      b32.in_valid = v;  b64.in_valid = v;
      b32.instr    = w;  b64.instr    = w;
      b32.imm_src  = s;  b64.imm_src  = s;
      b32.out_ready = ordy; b64.out_ready = ordy;
      flush = fl;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(1'b0, 32'h0, 3'd0, 1'b1, 1'b0);
      tick();
      tick();
      checks++;
      if ({b32.out_valid, b64.out_valid} !== 2'b00) begin
         failures++; $display("FAIL reset_out_valid got=%b exp=00", {b32.out_valid, b64.out_valid});
      end
      checks++;
      if (b32.imm_ext !== 32'h0 || b64.imm_ext !== 64'h0) begin
         failures++; $display("FAIL reset_imm_ext got=%h/%h exp=0", b32.imm_ext, b64.imm_ext);
      end
      checks++;
      if ({b32.imm_err, b64.imm_err} !== 2'b00) begin
         failures++; $display("FAIL reset_imm_err got=%b exp=00", {b32.imm_err, b64.imm_err});
      end
      rst = 1'b0;
      tick();
      checks++;
      if ({b32.in_ready, b64.in_ready, b32.out_valid, b64.out_valid} !== 4'b1100) begin
         failures++;
         $display("FAIL reset_release got=%b exp=1100",
                  {b32.in_ready, b64.in_ready, b32.out_valid, b64.out_valid});
      end
   endtask

   task automatic test_formats();
      vec_t vt[$];
      vt.push_back('{32'hFFF00093, 3'd0, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0});
      vt.push_back('{32'h7FF00093, 3'd0, 32'h000007FF, 64'h00000000000007FF, 1'b0});
      vt.push_back('{32'hFE20AE23, 3'd1, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0});
      vt.push_back('{32'hFE000CE3, 3'd2, 32'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8, 1'b0});
      vt.push_back('{32'h0080006F, 3'd3, 32'h00000008, 64'h0000000000000008, 1'b0});
      vt.push_back('{32'h8000006F, 3'd3, 32'hFFF00000, 64'hFFFFFFFFFFF00000, 1'b0});
      vt.push_back('{32'h800000B7, 3'd4, 32'h80000000, 64'hFFFFFFFF80000000, 1'b0});
      vt.push_back('{32'h01F0D093, 3'd5, 32'h00000001, 64'h0000000000000001, 1'b0});
      vt.push_back('{32'h000FD073, 3'd5, 32'h0000001F, 64'h000000000000001F, 1'b0});
      vt.push_back('{32'h03F09093, 3'd6, 32'h0000001F, 64'h000000000000003F, 1'b0});
      vt.push_back('{32'hFFFFFFFF, 3'd7, 32'h00000000, 64'h0000000000000000, 1'b1});
      foreach (vt[i]) begin
         drive(1'b1, vt[i].w, vt[i].s, 1'b1, 1'b0);
         tick();
         drive(1'b0, 32'h0, 3'd0, 1'b1, 1'b0);
         checks++;
         if ({b32.out_valid, b64.out_valid} !== 2'b11) begin
            failures++; $display("FAIL fmt%0d_valid got=%b exp=11", i, {b32.out_valid, b64.out_valid});
         end
         checks++;
         if (b32.imm_ext !== vt[i].e32) begin
            failures++; $display("FAIL fmt%0d_imm32 got=%h exp=%h", i, b32.imm_ext, vt[i].e32);
         end
         checks++;
         if (b64.imm_ext !== vt[i].e64) begin
            failures++; $display("FAIL fmt%0d_imm64 got=%h exp=%h", i, b64.imm_ext, vt[i].e64);
         end
         checks++;
         if (b32.imm_err !== vt[i].err || b64.imm_err !== vt[i].err) begin
            failures++;
            $display("FAIL fmt%0d_err got=%b/%b exp=%b", i, b32.imm_err, b64.imm_err, vt[i].err);
         end
         tick();
         checks++;
         if ({b32.out_valid, b64.out_valid} !== 2'b00) begin
            failures++; $display("FAIL fmt%0d_drained got=%b exp=00", i, {b32.out_valid, b64.out_valid});
         end
      end
   endtask

   task automatic test_backpressure();
      ent_t        e[3];
      int          seq[7];
      logic [63:0] r64;
      logic [63:0] r32;
      logic [31:0] r32l;
      int          k;
      for (int i = 0; i < 3; i++) begin
         e[i].w = $urandom();
         e[i].s = 3'($urandom_range(0, 6));
      end
      // Expected output-register occupant after each step (-1 = empty).
      seq = '{0, 0, 0, 0, 1, 2, -1};
      for (int st = 0; st < 7; st++) begin
         k = (st < 2) ? st : 2;
         drive(st < 6, e[k].w, e[k].s, st >= 4, 1'b0);
         tick();
         checks++;
         if ({b32.out_valid, b64.out_valid} !== {2{seq[st] >= 0}}) begin
            failures++;
            $display("FAIL bp%0d_valid got=%b exp=%b", st, {b32.out_valid, b64.out_valid}, seq[st] >= 0);
         end
         checks++;
         if ({b32.in_ready, b64.in_ready} !== {2{!(st >= 1 && st <= 3)}}) begin
            failures++;
            $display("FAIL bp%0d_ready got=%b exp=%b", st, {b32.in_ready, b64.in_ready},
                     !(st >= 1 && st <= 3));
         end
         if (seq[st] >= 0) begin
            r32  = ref_imm(e[seq[st]].w, e[seq[st]].s, 32);
            r32l = r32[31:0];
            r64  = ref_imm(e[seq[st]].w, e[seq[st]].s, 64);
            checks++;
            if (b32.imm_ext !== r32l || b64.imm_ext !== r64) begin
               failures++;
               $display("FAIL bp%0d_data got=%h/%h exp=%h/%h", st, b32.imm_ext, b64.imm_ext, r32l, r64);
            end
         end
      end
   endtask

   task automatic test_flush();
      logic [31:0] ew;
      // Both entries held, incoming word waiting during the flush.
      drive(1'b1, 32'h00100093, 3'd0, 1'b0, 1'b0); tick();
      drive(1'b1, 32'h00200093, 3'd0, 1'b0, 1'b0); tick();
      drive(1'b1, 32'h00300093, 3'd0, 1'b0, 1'b1); tick();
      drive(1'b0, 32'h0, 3'd0, 1'b1, 1'b0);
      checks++;
      if ({b32.out_valid, b64.out_valid, b32.in_ready, b64.in_ready} !== 4'b0011) begin
         failures++;
         $display("FAIL flush_full got=%b exp=0011",
                  {b32.out_valid, b64.out_valid, b32.in_ready, b64.in_ready});
      end
      tick();
      checks++;
      if ({b32.out_valid, b64.out_valid} !== 2'b00) begin
         failures++; $display("FAIL flush_full_after got=%b exp=00", {b32.out_valid, b64.out_valid});
      end
      // One entry held, and the flush-cycle word would otherwise be accepted.
      drive(1'b1, 32'h00400093, 3'd0, 1'b0, 1'b0); tick();
      drive(1'b1, 32'h00500093, 3'd0, 1'b0, 1'b1); tick();
      drive(1'b0, 32'h0, 3'd0, 1'b1, 1'b0);
      checks++;
      if ({b32.out_valid, b64.out_valid, b32.in_ready, b64.in_ready} !== 4'b0011) begin
         failures++;
         $display("FAIL flush_accept got=%b exp=0011",
                  {b32.out_valid, b64.out_valid, b32.in_ready, b64.in_ready});
      end
      tick();
      checks++;
      if ({b32.out_valid, b64.out_valid} !== 2'b00) begin
         failures++; $display("FAIL flush_discard got=%b exp=00", {b32.out_valid, b64.out_valid});
      end
      ew = 32'h00600093;
      drive(1'b1, ew, 3'd0, 1'b1, 1'b0); tick();
      drive(1'b0, 32'h0, 3'd0, 1'b1, 1'b0);
      checks++;
      if (b32.out_valid !== 1'b1 || b32.imm_ext !== 32'h6 || b64.imm_ext !== 64'h6) begin
         failures++;
         $display("FAIL flush_next got=%b/%h exp=1/00000006", b32.out_valid, b32.imm_ext);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      drive(1'b1, 32'hFFF00093, 3'd0, 1'b0, 1'b0); tick();
      drive(1'b1, 32'h80000037, 3'd4, 1'b0, 1'b0); tick();
      drive(1'b0, 32'h0, 3'd0, 1'b0, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({b32.out_valid, b64.out_valid} !== 2'b00) begin
         failures++; $display("FAIL rstmid_valid got=%b exp=00", {b32.out_valid, b64.out_valid});
      end
      checks++;
      if (b32.imm_ext !== 32'h0 || b64.imm_ext !== 64'h0 || b32.imm_err !== 1'b0) begin
         failures++; $display("FAIL rstmid_data got=%h/%h exp=0", b32.imm_ext, b64.imm_ext);
      end
      checks++;
      if ({b32.in_ready, b64.in_ready} !== 2'b11) begin
         failures++; $display("FAIL rstmid_ready got=%b exp=11", {b32.in_ready, b64.in_ready});
      end
      tick();
      rst = 1'b0;
      drive(1'b1, 32'h02A00093, 3'd0, 1'b1, 1'b0); tick();
      drive(1'b0, 32'h0, 3'd0, 1'b1, 1'b0);
      checks++;
      if (b32.out_valid !== 1'b1 || b32.imm_ext !== 32'h2A || b64.imm_ext !== 64'h2A) begin
         failures++;
         $display("FAIL rstmid_latency got=%b/%h exp=1/0000002a", b32.out_valid, b32.imm_ext);
      end
      tick();
      checks++;
      if ({b32.out_valid, b64.out_valid} !== 2'b00) begin
         failures++; $display("FAIL rstmid_drain got=%b exp=00", {b32.out_valid, b64.out_valid});
      end
   endtask

   task automatic test_soak();
      ent_t        q[$];
      ent_t        f;
      logic        v;
      logic        ordy;
      logic        fl;
      logic        exp_v;
      logic        exp_r;
      logic [63:0] r32;
      logic [63:0] r64;
      logic [31:0] r32l;
      int          rdy_pct;
      drive(1'b0, 32'h0, 3'd0, 1'b1, 1'b1); tick();
      drive(1'b0, 32'h0, 3'd0, 1'b1, 1'b0);
      rdy_pct = 50;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (cyc % 200 == 0) rdy_pct = $urandom_range(10, 95);
         v    = ($urandom_range(0, 99) < 70);
         ordy = ($urandom_range(0, 99) < rdy_pct);
         fl   = ($urandom_range(0, 39) == 0);
         drive(v, $urandom(), 3'($urandom_range(0, 7)), ordy, fl);
         @(negedge clk);
         exp_v = (q.size() != 0);
         exp_r = (q.size() < 2);
         checks++;
         if ({b32.out_valid, b64.out_valid} !== {2{exp_v}}) begin
            failures++;
            $display("FAIL soak%0d_valid got=%b exp=%b", cyc, {b32.out_valid, b64.out_valid}, exp_v);
         end
         checks++;
         if ({b32.in_ready, b64.in_ready} !== {2{exp_r}}) begin
            failures++;
            $display("FAIL soak%0d_ready got=%b exp=%b", cyc, {b32.in_ready, b64.in_ready}, exp_r);
         end
         if (exp_v) begin
            f    = q[0];
            r32  = ref_imm(f.w, f.s, 32);
            r32l = r32[31:0];
            r64  = ref_imm(f.w, f.s, 64);
            checks++;
            if (b32.imm_ext !== r32l || b64.imm_ext !== r64 ||
                b32.imm_err !== (f.s == 3'd7) || b64.imm_err !== (f.s == 3'd7)) begin
               failures++;
               $display("FAIL soak%0d_data got=%h/%h/%b exp=%h/%h/%b", cyc, b32.imm_ext,
                        b64.imm_ext, b32.imm_err, r32l, r64, f.s == 3'd7);
            end
         end
         if (fl) begin
            q.delete();
         end else begin
            if (exp_v && ordy) void'(q.pop_front());
            if (v && exp_r) q.push_back('{b32.instr, b32.imm_src});
         end
         @(posedge clk);
         #1;
      end
      drive(1'b0, 32'h0, 3'd0, 1'b1, 1'b0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_formats();
      test_backpressure();
      test_flush();
      test_reset_mid();
      test_soak();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
